nios2_debug_scan_master: RTL

// - Host-side initiator for the Nios II debug slave virtual-JTAG interface: drives ir_in, tck, tdi and the

---
 rtl/nios2_debug_scan_master_if.sv | 31 +++
 rtl/nios2_debug_scan_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nios2_debug_scan_master_if.sv
// -----------------------------------------------------------------------------
// nios2_debug_scan_master_if
// Command/response handshake bundle for the Nios II debug scan master.
//   cmd_valid / cmd_ready   command handshake (host -> scan master)
//   cmd_ir[1:0]             IR value to select
//   cmd_dr[DR_WIDTH-1:0]    DR word to shift in, LSB first
//   rsp_valid / rsp_ready   response handshake (scan master -> host)
//   rsp_dr[DR_WIDTH-1:0]    captured tdo word, bit 0 = first bit out
// Modports: master = host side, slave = scan master side.
// -----------------------------------------------------------------------------
interface nios2_debug_scan_master_if #(
  parameter int DR_WIDTH = 38
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_dr;

  modport master (
    output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_dr
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_dr
  );
endinterface

// File: rtl/nios2_debug_scan_master.sv
// -----------------------------------------------------------------------------
// nios2_debug_scan_master
// Host-side initiator for the Nios II debug slave virtual-JTAG port. Each
// accepted command runs one IR select (UIR) followed by a CDR/SDR/UDR scan of
// DR_WIDTH bits; the tdo bits captured during SDR are returned as a response.
//
// Ports:
//   clk               system clock (only clock)
//   reset_n           synchronous active-low reset
//   bus (slave)       cmd_valid/cmd_ready/cmd_ir/cmd_dr, rsp_valid/rsp_ready/rsp_dr
//   tck_o             generated scan clock level (register)
//   tdi_o / tdo_i     serial data to / from the debug slave
//   ir_in_o           registered IR value
//   vs_uir_o, vs_cdr_o, vs_sdr_o, vs_udr_o   virtual-state strobes
//   jtag_state_rti_o  high while idle
//
// Parameters: DR_WIDTH (scan length), CLK_DIV (clk cycles per tck half-period).
// Optional feature: define DEBUG_SCAN_IR_CACHE_EN to skip UIR when the
// requested IR matches the previously selected one.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | run-test/idle, tck parked low, cmd_ready high
// UIR   | one tck period with vs_uir, ir_in already loaded
// CDR   | one tck period with vs_cdr
// SDR   | DR_WIDTH tck periods: tdi driven on falls, tdo sampled on rises
// UDR   | one tck period with vs_udr
// RESP  | tck parked low, rsp_valid held until rsp_ready
// -----------------------------------------------------------------------------
module nios2_debug_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int CLK_DIV  = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  nios2_debug_scan_master_if.slave    bus,
  output logic                        tck_o,
  output logic                        tdi_o,
  input  logic                        tdo_i,
  output logic [1:0]                  ir_in_o,
  output logic                        vs_uir_o,
  output logic                        vs_cdr_o,
  output logic                        vs_sdr_o,
  output logic                        vs_udr_o,
  output logic                        jtag_state_rti_o
);

  localparam int BW    = $clog2(DR_WIDTH + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0]    BIT_LAST = BW'(DR_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                tck_q, tck_d;
  logic                tdi_q, tdi_d;
  logic [1:0]          ir_q, ir_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic [DR_WIDTH-1:0] cap_q, cap_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                vs_uir_q, vs_cdr_q, vs_sdr_q, vs_udr_q;
  logic                rti_q;

`ifdef DEBUG_SCAN_IR_CACHE_EN
  logic [1:0]          cache_ir_q, cache_ir_d;
  logic                cache_vld_q, cache_vld_d;
`endif

  logic                active;
  logic                wrap;
  logic                rise;
  logic                fall;
  logic [BW-1:0]       bit_inc;

  // The divider only runs while scanning; IDLE and RESP are always entered on
  // a fall, so the divider is parked at 0 and tck is low there.
  assign active  = (state_q == ST_UIR) || (state_q == ST_CDR) ||
                   (state_q == ST_SDR) || (state_q == ST_UDR);
  assign wrap    = (div_q == DIV_LAST);
  assign rise    = active && wrap && !tck_q;
  assign fall    = active && wrap &&  tck_q;
  assign bit_inc = bit_q + BW'(1);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tck_d   = tck_q;
    tdi_d   = tdi_q;
    ir_d    = ir_q;
    shift_d = shift_q;
    cap_d   = cap_q;
    bit_d   = bit_q;
`ifdef DEBUG_SCAN_IR_CACHE_EN
    cache_ir_d  = cache_ir_q;
    cache_vld_d = cache_vld_q;
`endif

    if (active) begin
      div_d = wrap ? '0 : div_q + DIV_W'(1);
      if (wrap) tck_d = ~tck_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          ir_d    = bus.cmd_ir;
          shift_d = bus.cmd_dr;
          bit_d   = '0;
          state_d = ST_UIR;
`ifdef DEBUG_SCAN_IR_CACHE_EN
          if (cache_vld_q && (bus.cmd_ir == cache_ir_q)) state_d = ST_CDR;
          cache_ir_d  = bus.cmd_ir;
          cache_vld_d = 1'b1;
`endif
        end
      end
      ST_UIR: begin
        if (fall) state_d = ST_CDR;
      end
      ST_CDR: begin
        // First data bit is presented on the fall that enters SDR so it is
        // stable at the first SDR rise.
        if (fall) begin
          state_d = ST_SDR;
          tdi_d   = shift_q[0];
        end
      end
      ST_SDR: begin
        if (rise) cap_d = {tdo_i, cap_q[DR_WIDTH-1:1]};
        if (fall) begin
          bit_d = bit_inc;
          if (bit_inc == BIT_LAST) begin
            state_d = ST_UDR;
            tdi_d   = 1'b0;
          end else begin
            shift_d = shift_q >> 1;
            tdi_d   = shift_q[1];
          end
        end
      end
      ST_UDR: begin
        if (fall) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      tck_q    <= 1'b0;
      tdi_q    <= 1'b0;
      ir_q     <= 2'b00;
      shift_q  <= '0;
      cap_q    <= '0;
      bit_q    <= '0;
      vs_uir_q <= 1'b0;
      vs_cdr_q <= 1'b0;
      vs_sdr_q <= 1'b0;
      vs_udr_q <= 1'b0;
      rti_q    <= 1'b1;
`ifdef DEBUG_SCAN_IR_CACHE_EN
      cache_ir_q  <= 2'b00;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tck_q    <= tck_d;
      tdi_q    <= tdi_d;
      ir_q     <= ir_d;
      shift_q  <= shift_d;
      cap_q    <= cap_d;
      bit_q    <= bit_d;
      // Strobes are decoded from the next state so they switch together with
      // the state, i.e. only on tck falls (or on leaving IDLE).
      vs_uir_q <= (state_d == ST_UIR);
      vs_cdr_q <= (state_d == ST_CDR);
      vs_sdr_q <= (state_d == ST_SDR);
      vs_udr_q <= (state_d == ST_UDR);
      rti_q    <= (state_d == ST_IDLE);
`ifdef DEBUG_SCAN_IR_CACHE_EN
      cache_ir_q  <= cache_ir_d;
      cache_vld_q <= cache_vld_d;
`endif
    end
  end

  assign bus.cmd_ready    = (state_q == ST_IDLE);
  assign bus.rsp_valid    = (state_q == ST_RESP);
  assign bus.rsp_dr       = cap_q;
  assign tck_o            = tck_q;
  assign tdi_o            = tdi_q;
  assign ir_in_o          = ir_q;
  assign vs_uir_o         = vs_uir_q;
  assign vs_cdr_o         = vs_cdr_q;
  assign vs_sdr_o         = vs_sdr_q;
  assign vs_udr_o         = vs_udr_q;
  assign jtag_state_rti_o = rti_q;

endmodule
